// File: rtl/pow2_map.sv
// Log-to-linear fraction converter: out ~= (2^(in/2^IN) - 1) * 2^OUT, rounded half away from zero, saturating.
// Latency 1 cycle, full throughput, no backpressure; table is an elaboration-time constant.
module pow2_map #(
    parameter int IN  = 10,
    parameter int OUT = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [IN-1:0]  in,
    output logic           out_valid,
    output logic [OUT-1:0] out
);

    localparam int DEPTH = 2 ** IN;

    function automatic logic [OUT-1:0] entry(input int f);
        real y;
        int  r;
        int  top;
        top = (1 << OUT) - 1;
        y   = ($pow(2.0, real'(f) / real'(DEPTH)) - 1.0) * real'(top + 1);
        r   = $rtoi($floor(y + 0.5));
        // Only the last few codes can round up to 2^OUT; clamp instead of wrapping.
        if (r > top) begin
            r = top;
        end
        entry = OUT'(r);
    endfunction

    logic [OUT-1:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam logic [OUT-1:0] VAL = entry(g);
        assign rom[g] = VAL;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= rom[in];
            end
        end
    end

endmodule

// File: tb/tb_pow2_map.sv
// Directed plus randomized check of pow2_map at (IN=10,OUT=8) and (IN=4,OUT=4) against a real-math model.
module tb_pow2_map;

    logic       clock = 1'b0;
    logic       reset;
    logic       v10;
    logic [9:0] f10;
    logic       ov10;
    logic [7:0] o10;
    logic       v4;
    logic [3:0] f4;
    logic       ov4;
    logic [3:0] o4;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    pow2_map dut10 (
        .clock(clock), .reset(reset),
        .in_valid(v10), .in(f10),
        .out_valid(ov10), .out(o10)
    );

    pow2_map #(.IN(4), .OUT(4)) dut4 (
        .clock(clock), .reset(reset),
        .in_valid(v4), .in(f4),
        .out_valid(ov4), .out(o4)
    );

    // Reference: evaluate 2^x - 1 scaled, round half up on the (non-negative) value, clamp.
    function automatic int model(input int f, input int inw, input int outw);
        real x, y, fracpart;
        int  r, limit;
        x     = real'(f) / (2.0 ** inw);
        y     = ((2.0 ** x) - 1.0) * (2.0 ** outw);
        r     = $rtoi(y);
        fracpart = y - real'(r);
        if (fracpart >= 0.5) r = r + 1;
        limit = (1 << outw) - 1;
        if (r > limit) r = limit;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step10(input logic v, input logic [9:0] f);
        v10 = v;
        f10 = f;
        tick();
    endtask

    int exp_out;
    int prev;
    int fv;
    int dir_f[5]   = '{0, 256, 512, 768, 1023};
    int dir_exp[5] = '{0, 48, 106, 175, 255};

    initial begin
        reset = 1'b1;
        v10 = 1'b0; f10 = '0;
        v4  = 1'b0; f4  = '0;
        tick();
        tick();
        check("reset_out", 32'(o10), 0);
        check("reset_valid", 32'(ov10), 0);
        check("reset_valid4", 32'(ov4), 0);

        reset = 1'b0;
        step10(1'b0, 10'h3ff);
        check("idle_valid", 32'(ov10), 0);

        // Single samples separated by idle cycles.
        step10(1'b1, 10'd0);   check("f0", 32'(o10), 0);     check("f0_v", 32'(ov10), 1);
        step10(1'b0, 10'bx);   check("f0_idle_v", 32'(ov10), 0);
        step10(1'b1, 10'd1);   check("f1", 32'(o10), 0);
        step10(1'b0, 10'bx);
        step10(1'b1, 10'd256); check("f256", 32'(o10), 48);
        step10(1'b0, 10'bx);   check("f256_hold", 32'(o10), 48);
        step10(1'b1, 10'd512); check("f512", 32'(o10), 106);
        step10(1'b0, 10'bx);
        step10(1'b1, 10'd768); check("f768", 32'(o10), 175);
        step10(1'b0, 10'bx);
        step10(1'b1, 10'd1023); check("f1023_sat", 32'(o10), 255);
        step10(1'b0, 10'bx);

        // Back-to-back stream.
        for (int i = 0; i < 5; i++) begin
            step10(1'b1, 10'(dir_f[i]));
            check("b2b_out", 32'(o10), 32'(dir_exp[i]));
            check("b2b_valid", 32'(ov10), 1);
        end
        step10(1'b0, 10'bx);
        check("drop_valid", 32'(ov10), 0);
        check("drop_hold", 32'(o10), 255);

        // Exhaustive sweep with random idle gaps; also monotonicity.
        prev = 0;
        for (int f = 0; f < 1024; f++) begin
            if ($urandom_range(3) == 0) begin
                step10(1'b0, 10'bx);
                check("sweep_gap_v", 32'(ov10), 0);
            end
            step10(1'b1, 10'(f));
            exp_out = model(f, 10, 8);
            check("sweep", 32'(o10), 32'(exp_out));
            assert (int'(o10) >= prev) else begin
                miscompares++;
                $error("FAIL monotonic f=%0d observed=%0d previous=%0d", f, o10, prev);
            end
            vectors++;
            prev = int'(o10);
        end

        // Random stream with random qualifiers; out must hold across invalid cycles.
        exp_out = int'(o10);
        for (int i = 0; i < 400; i++) begin
            fv = int'($urandom_range(1023));
            if ($urandom_range(2) != 0) begin
                step10(1'b1, 10'(fv));
                exp_out = model(fv, 10, 8);
                check("rand_v", 32'(ov10), 1);
            end else begin
                step10(1'b0, 10'(fv));
                check("rand_idle_v", 32'(ov10), 0);
            end
            check("rand_out", 32'(o10), 32'(exp_out));
        end

        // Reset wins over a simultaneous valid sample.
        reset = 1'b1;
        step10(1'b1, 10'd512);
        check("rst_vs_valid_out", 32'(o10), 0);
        check("rst_vs_valid_v", 32'(ov10), 0);
        reset = 1'b0;
        step10(1'b0, 10'd0);
        check("post_rst_v", 32'(ov10), 0);
        step10(1'b1, 10'd512);
        check("post_rst_first", 32'(o10), 106);
        check("post_rst_first_v", 32'(ov10), 1);
        step10(1'b0, 10'bx);

        // Small configuration: exhaustive plus named points.
        for (int f = 0; f < 16; f++) begin
            v4 = 1'b1;
            f4 = 4'(f);
            tick();
            check("small_sweep", 32'(o4), 32'(model(f, 4, 4)));
            check("small_v", 32'(ov4), 1);
            if (f == 8)  check("small_f8", 32'(o4), 7);
            if (f == 15) check("small_f15", 32'(o4), 15);
        end
        v4 = 1'b0;
        tick();
        check("small_idle_v", 32'(ov4), 0);
        check("small_hold", 32'(o4), 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
